// File: rtl/stereo_gray_pairer.sv
// Stereo RGB-to-grey pairer.
// Each camera side converts RGB to a 9-bit grey value, registers it for one
// stage, and queues it in its own FIFO. When both FIFOs hold data, one entry
// from each is popped together into a ready/valid output register. Pairing
// follows arrival order on each side, so the two streams may be skewed.
// Column and row position are tracked per transfer. A write into a full FIFO
// that cannot be relieved by a same-cycle pop is an overflow: the sample is
// dropped and the block locks in ERROR until the next frame start.
module stereo_gray_pairer #(
    parameter int WIDTH = 800,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid_l,
    input  logic       i_valid_r,
    input  logic [9:0] i_R_l,
    input  logic [9:0] i_G_l,
    input  logic [9:0] i_B_l,
    input  logic [9:0] i_R_r,
    input  logic [9:0] i_G_r,
    input  logic [9:0] i_B_r,
    input  logic       i_sof,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [8:0] o_data_l,
    output logic [8:0] o_data_r,
    output logic       o_sol,
    output logic       o_eol,
    output logic [9:0] o_row,
    output logic       o_overflow
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, ERROR} state_t;

    state_t state, state_next;

    // Side index 0 = left camera, 1 = right camera.
    logic [1:0]       valid_in;
    logic [1:0][9:0]  r_in, g_in, b_in;
    logic [1:0][8:0]  head;
    logic [1:0]       empty;
    logic [1:0]       over;

    logic             flush_now;
    logic             run_now;
    logic             pop;
    logic             overflow_hit;
    logic [COLW-1:0]  col;

    assign valid_in[0] = i_valid_l;
    assign valid_in[1] = i_valid_r;
    assign r_in[0] = i_R_l;
    assign g_in[0] = i_G_l;
    assign b_in[0] = i_B_l;
    assign r_in[1] = i_R_r;
    assign g_in[1] = i_G_r;
    assign b_in[1] = i_B_r;

    // A frame start clears everything at the edge that enters FLUSH and again
    // at the edge that leaves it, so no stale pair is ever visible in FLUSH.
    assign flush_now    = i_sof || (state == FLUSH);
    assign run_now      = (state == RUN) && !i_sof;
    assign pop          = run_now && !empty[0] && !empty[1] && (!o_valid || i_ready);
    assign overflow_hit = run_now && (over != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic [11:0]   sum;
            logic [8:0]    grey;
            logic          stage_valid;
            logic [8:0]    stage_data;
            logic [8:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr, rd_ptr;
            logic [CW-1:0] count;
            logic          full;
            logic          push;

            // Sum fits 12 bits (max 4092), so the shifted result never saturates.
            assign sum  = {2'b00, r_in[gi]} + {1'b0, g_in[gi], 1'b0} + {2'b00, b_in[gi]};
            assign grey = 9'(sum >> 3);

            assign full      = (count == CW'(DEPTH));
            assign push      = run_now && stage_valid && (!full || pop);
            assign over[gi]  = run_now && stage_valid && full && !pop;
            assign empty[gi] = (count == '0);
            assign head[gi]  = mem[rd_ptr];

            // Conversion stage: capture only while running; otherwise inputs are ignored.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_valid <= 1'b0;
                    stage_data  <= '0;
                end else if (flush_now) begin
                    stage_valid <= 1'b0;
                    stage_data  <= '0;
                end else if (state == RUN) begin
                    stage_valid <= valid_in[gi];
                    stage_data  <= grey;
                end else begin
                    stage_valid <= 1'b0;
                end
            end

            // FIFO storage; contents are don't-care until the pointers cover them.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= stage_data;
                end
            end

            // FIFO pointers and occupancy; push+pop together keep the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else if (flush_now) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (push && !pop) begin
                        count <= count + 1'b1;
                    end else if (pop && !push) begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a frame start always wins over an overflow.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_sof) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            RUN: begin
                if (i_sof) begin
                    state_next = FLUSH;
                end else if (overflow_hit) begin
                    state_next = ERROR;
                end
            end
            ERROR:   if (i_sof) state_next = FLUSH;
            default: state_next = IDLE;
        endcase
    end

    // Output pair register: load on pop, retire on transfer, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_data_l <= '0;
            o_data_r <= '0;
        end else if (flush_now) begin
            o_valid  <= 1'b0;
            o_data_l <= '0;
            o_data_r <= '0;
        end else if (overflow_hit) begin
            o_valid  <= 1'b0;
        end else if (pop) begin
            o_valid  <= 1'b1;
            o_data_l <= head[0];
            o_data_r <= head[1];
        end else if (o_valid && i_ready) begin
            o_valid  <= 1'b0;
        end
    end

    // Column and row position, advanced once per accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            o_row <= '0;
        end else if (flush_now) begin
            col   <= '0;
            o_row <= '0;
        end else if ((state == RUN) && o_valid && i_ready) begin
            if (col == COLW'(WIDTH - 1)) begin
                col   <= '0;
                o_row <= o_row + 1'b1;
            end else begin
                col   <= col + 1'b1;
            end
        end
    end

    // Sticky overflow flag; only reset clears it, frame starts do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (overflow_hit) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_sol = o_valid && (col == '0);
    assign o_eol = o_valid && (col == COLW'(WIDTH - 1));

endmodule
